// File: rtl/vec_mem_stage_pkg.sv
// Shared types and default geometry for the vector MEM stage.
package vec_mem_pkg;

    localparam int unsigned DEF_ROW_STRIDE = 640;
    localparam int unsigned DEF_ADDR_W     = 20;
    localparam int unsigned DEF_DATA_W     = 48;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } mem_state_t;

    typedef struct packed {
        logic                  valid;
        logic                  reg_wr;
        logic [3:0]            rd;
        logic [DEF_DATA_W-1:0] data;
        logic [3:0]            flags;
        logic                  fault;
    } mem_wb_t;

endpackage

// File: rtl/vec_mem_stage_if.sv
// Data-memory port: request/grant for the address phase, rvalid for read data.
interface vec_mem_if
    import vec_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) ();

    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/vec_mem_stage_addr_gen.sv
// Converts a {row,col} ALU result into a linear word address and flags
// addresses beyond the end of data memory.
module vec_addr_gen
    import vec_mem_pkg::*;
#(
    parameter int unsigned ROW_STRIDE = DEF_ROW_STRIDE,
    parameter int unsigned ADDR_W     = DEF_ADDR_W
) (
    input  logic [31:0]       rowcol,
    output logic [ADDR_W-1:0] addr,
    output logic              oob
);

    localparam logic [32:0] DEPTH = 33'd1 << ADDR_W;

    logic [31:0] addr32;

    // Range check runs on the full 32-bit product; truncation happens only afterwards.
    always_comb begin
        addr32 = 32'(rowcol[31:16]) * 32'(ROW_STRIDE) + 32'(rowcol[15:0]);
        oob    = ({1'b0, addr32} >= DEPTH);
        addr   = addr32[ADDR_W-1:0];
    end

endmodule

// File: rtl/vec_mem_stage.sv
// MEM stage of the vector CPU: runs loads/stores over a req/gnt/rvalid port,
// stalls EX/MEM while an access is in flight and registers the MEM/WB bundle.
module vec_mem_stage
    import vec_mem_pkg::*;
#(
    parameter int unsigned ROW_STRIDE = DEF_ROW_STRIDE,
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic              ex_mem_rd,
    input  logic              ex_mem_wr,
    input  logic              ex_reg_wr,
    input  logic [3:0]        ex_rd,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [3:0]        ex_flags,
    input  logic [DATA_W-1:0] ex_wdata,
    output logic              stall_o,
    vec_mem_if.master         mem,
    output logic              wb_valid,
    output logic              wb_reg_wr,
    output logic [3:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic [3:0]        wb_flags,
    output logic              wb_fault
);

    mem_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              pend_reg_wr_q, pend_reg_wr_d;
    logic [3:0]        pend_rd_q, pend_rd_d;
    logic [3:0]        pend_flags_q, pend_flags_d;
    logic [DATA_W-1:0] pend_result_q, pend_result_d;
    mem_wb_t           wb_q, wb_d;

    logic [ADDR_W-1:0] gen_addr;
    logic              gen_oob;
    logic              mem_op;

    vec_addr_gen #(
        .ROW_STRIDE(ROW_STRIDE),
        .ADDR_W    (ADDR_W)
    ) u_addr_gen (
        .rowcol(ex_result[31:0]),
        .addr  (gen_addr),
        .oob   (gen_oob)
    );

    assign mem_op = ex_valid & (ex_mem_rd | ex_mem_wr);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        we_d          = we_q;
        pend_reg_wr_d = pend_reg_wr_q;
        pend_rd_d     = pend_rd_q;
        pend_flags_d  = pend_flags_q;
        pend_result_d = pend_result_q;
        wb_d          = wb_q;
        wb_d.valid    = 1'b0;
        stall_o       = 1'b0;
        mem.req       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (ex_valid && !mem_op) begin
                    wb_d = '{valid: 1'b1, reg_wr: ex_reg_wr, rd: ex_rd, data: ex_result,
                             flags: ex_flags, fault: 1'b0};
                end else if (mem_op && gen_oob) begin
                    wb_d = '{valid: 1'b1, reg_wr: 1'b0, rd: ex_rd, data: ex_result,
                             flags: ex_flags, fault: 1'b1};
                end else if (mem_op) begin
                    stall_o       = 1'b1;
                    addr_d        = gen_addr;
                    wdata_d       = ex_wdata;
                    we_d          = ex_mem_wr;
                    pend_reg_wr_d = ex_reg_wr;
                    pend_rd_d     = ex_rd;
                    pend_flags_d  = ex_flags;
                    pend_result_d = ex_result;
                    state_d       = REQ;
                end
            end
            REQ: begin
                mem.req = 1'b1;
                stall_o = 1'b1;
                if (mem.gnt) begin
                    if (we_q) begin
                        wb_d = '{valid: 1'b1, reg_wr: 1'b0, rd: pend_rd_q, data: pend_result_q,
                                 flags: pend_flags_q, fault: 1'b0};
                        stall_o = 1'b0;
                        state_d = IDLE;
                    end else if (mem.rvalid) begin
                        wb_d = '{valid: 1'b1, reg_wr: pend_reg_wr_q, rd: pend_rd_q, data: mem.rdata,
                                 flags: pend_flags_q, fault: 1'b0};
                        stall_o = 1'b0;
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                stall_o = 1'b1;
                if (mem.rvalid) begin
                    wb_d = '{valid: 1'b1, reg_wr: pend_reg_wr_q, rd: pend_rd_q, data: mem.rdata,
                             flags: pend_flags_q, fault: 1'b0};
                    stall_o = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            we_q          <= 1'b0;
            pend_reg_wr_q <= 1'b0;
            pend_rd_q     <= '0;
            pend_flags_q  <= '0;
            pend_result_q <= '0;
            wb_q          <= '0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            state_q       <= state_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            we_q          <= we_d;
            pend_reg_wr_q <= pend_reg_wr_d;
            pend_rd_q     <= pend_rd_d;
            pend_flags_q  <= pend_flags_d;
            pend_result_q <= pend_result_d;
            wb_q          <= wb_d;
        end
    end

    assign mem.addr  = addr_q;
    assign mem.wdata = wdata_q;
    assign mem.we    = we_q;

    assign wb_valid  = wb_q.valid;
    assign wb_reg_wr = wb_q.reg_wr;
    assign wb_rd     = wb_q.rd;
    assign wb_data   = wb_q.data;
    assign wb_flags  = wb_q.flags;
    assign wb_fault  = wb_q.fault;

endmodule
